// File: rtl/spi_recv_con.sv
// rtl/spi_recv_con.sv - SPI receiver: synchronizes CS/DCLK/data pins, shifts MSB-first words, strobes completed words
module spi_recv_con #(
  parameter int DATA_WIDTH  = 8,
  parameter int LINES       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                                 clk_in,
  input  logic                                 rst_n_in,
  input  logic [LINES-1:0]                     chip_data_in,
  input  logic                                 chip_clk_in,
  input  logic                                 chip_sel_in,
  output logic [LINES-1:0][DATA_WIDTH-1:0]     data_out,
  output logic                                 data_valid_out,
  output logic                                 frame_err_out,
  output logic                                 busy_out
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [0:0] {IDLE, RECV} state_t;

  logic [SYNC_STAGES-1:0]              cs_ff;
  logic [SYNC_STAGES-1:0]              dclk_ff;
  logic [LINES-1:0][SYNC_STAGES-1:0]   din_ff;
  logic                                dclk_dly;
  logic                                cs_sync;
  logic                                dclk_sync;
  logic [LINES-1:0]                    din_sync;
  logic                                rise;

  state_t                              state;
  logic [CNT_W-1:0]                    cnt;
  logic [LINES-1:0][DATA_WIDTH-1:0]    shift;
  logic                                err_pend;

  // CS chain resets high so an idle bus is not mistaken for a frame start
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cs_ff    <= '1;
      dclk_ff  <= '0;
      din_ff   <= '0;
      dclk_dly <= 1'b0;
    end else begin
      cs_ff    <= {cs_ff[SYNC_STAGES-2:0], chip_sel_in};
      dclk_ff  <= {dclk_ff[SYNC_STAGES-2:0], chip_clk_in};
      for (int i = 0; i < LINES; i++) begin
        din_ff[i] <= {din_ff[i][SYNC_STAGES-2:0], chip_data_in[i]};
      end
      dclk_dly <= dclk_ff[SYNC_STAGES-1];
    end
  end

  always_comb begin
    din_sync = '0;
    for (int i = 0; i < LINES; i++) begin
      din_sync[i] = din_ff[i][SYNC_STAGES-1];
    end
  end

  assign cs_sync   = cs_ff[SYNC_STAGES-1];
  assign dclk_sync = dclk_ff[SYNC_STAGES-1];
  assign rise      = dclk_sync & ~dclk_dly;

  // busy_out and frame_err_out lag the state change by one cycle
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state          <= IDLE;
      cnt            <= '0;
      shift          <= '0;
      data_out       <= '0;
      data_valid_out <= 1'b0;
      frame_err_out  <= 1'b0;
      busy_out       <= 1'b0;
      err_pend       <= 1'b0;
    end else begin
      data_valid_out <= 1'b0;
      frame_err_out  <= err_pend;
      err_pend       <= 1'b0;
      busy_out       <= (state == RECV);
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!cs_sync) begin
            state <= RECV;
          end
        end
        RECV: begin
          if (cs_sync) begin
            err_pend <= (cnt != '0);
            cnt      <= '0;
            state    <= IDLE;
          end else if (rise) begin
            for (int i = 0; i < LINES; i++) begin
              shift[i] <= {shift[i][DATA_WIDTH-2:0], din_sync[i]};
            end
            if (cnt == CNT_W'(DATA_WIDTH - 1)) begin
              for (int i = 0; i < LINES; i++) begin
                data_out[i] <= {shift[i][DATA_WIDTH-2:0], din_sync[i]};
              end
              data_valid_out <= 1'b1;
              cnt            <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_recv_con.sv
// tb/tb_spi_recv_con.sv - directed bench for spi_recv_con with one-line and three-line instances
module tb_spi_recv_con;

  localparam int HALF = 50;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [2:0]           chip_data = 3'b000;
  logic                 dclk = 1'b0;
  logic                 cs = 1'b1;

  logic [0:0][7:0]      d1;
  logic                 v1, e1, busy1;
  logic [2:0][7:0]      d3;
  logic                 v3, e3, busy3;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int vcnt1 = 0, ecnt1 = 0, vcnt3 = 0, ecnt3 = 0, busy_hi = 0, both_cnt = 0;
  logic [7:0]      last_val1 = 8'h00, prev_val1 = 8'h00;
  int              last_t1 = 0, prev_t1 = 0;
  logic [2:0][7:0] last3 = '0;
  int              t_rise = 0;

  spi_recv_con #(.DATA_WIDTH(8), .LINES(1), .SYNC_STAGES(2)) dut1 (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .chip_data_in   (chip_data[0:0]),
    .chip_clk_in    (dclk),
    .chip_sel_in    (cs),
    .data_out       (d1),
    .data_valid_out (v1),
    .frame_err_out  (e1),
    .busy_out       (busy1)
  );

  spi_recv_con #(.DATA_WIDTH(8), .LINES(3), .SYNC_STAGES(2)) dut3 (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .chip_data_in   (chip_data),
    .chip_clk_in    (dclk),
    .chip_sel_in    (cs),
    .data_out       (d3),
    .data_valid_out (v3),
    .frame_err_out  (e3),
    .busy_out       (busy3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (v1) begin
      vcnt1++;
      prev_val1 = last_val1;
      last_val1 = d1[0];
      prev_t1 = last_t1;
      last_t1 = cyc;
    end
    if (e1) ecnt1++;
    if (v3) begin
      vcnt3++;
      last3 = d3;
    end
    if (e3) ecnt3++;
    if (busy1) busy_hi++;
    if ((v1 && e1) || (v3 && e3)) both_cnt++;
  end

  task automatic send_bits(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                           input int nbits);
    for (int b = 7; b >= 8 - nbits; b--) begin
      chip_data = {w2[b], w1[b], w0[b]};
      repeat (HALF) @(negedge clk);
      t_rise = cyc;
      dclk = 1'b1;
      repeat (HALF) @(negedge clk);
      dclk = 1'b0;
    end
  endtask

  task automatic frame_begin();
    @(negedge clk);
    cs = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (HALF) @(negedge clk);
    cs = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({d1, v1, e1, busy1} !== '0) begin
      errors++;
      $display("FAIL reset_dut1 got d=%h v=%b e=%b b=%b want all 0", d1, v1, e1, busy1);
    end
    checks++;
    if ({d3, v3, e3, busy3} !== '0) begin
      errors++;
      $display("FAIL reset_dut3 got d=%h v=%b e=%b b=%b want all 0", d3, v3, e3, busy3);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single();
    int v0, e0;
    v0 = vcnt1; e0 = ecnt1;
    frame_begin();
    checks++;
    if (busy1 !== 1'b1) begin
      errors++;
      $display("FAIL single_busy_hi got %b want 1", busy1);
    end
    send_bits(8'hA5, 8'h00, 8'h00, 8);
    checks++;
    if (vcnt1 - v0 != 1 || last_val1 !== 8'hA5) begin
      errors++;
      $display("FAIL single_word got n=%0d val=%h want n=1 val=a5", vcnt1 - v0, last_val1);
    end
    checks++;
    if (last_t1 - t_rise != 3) begin
      errors++;
      $display("FAIL single_latency got %0d want 3", last_t1 - t_rise);
    end
    repeat (HALF) @(negedge clk);
    cs = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy1 !== 1'b1) begin
      errors++;
      $display("FAIL single_busy_hold got %b want 1", busy1);
    end
    @(negedge clk);
    checks++;
    if (busy1 !== 1'b0) begin
      errors++;
      $display("FAIL single_busy_fall got %b want 0", busy1);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (ecnt1 != e0 || d1[0] !== 8'hA5) begin
      errors++;
      $display("FAIL single_after got err=%0d d=%h want err=0 d=a5", ecnt1 - e0, d1[0]);
    end
  endtask

  task automatic test_multi_line();
    int v0;
    v0 = vcnt3;
    frame_begin();
    send_bits(8'h3C, 8'hFF, 8'h01, 8);
    frame_end();
    checks++;
    if (vcnt3 - v0 != 1) begin
      errors++;
      $display("FAIL multi_count got %0d want 1", vcnt3 - v0);
    end
    checks++;
    if (last3[0] !== 8'h3C || last3[1] !== 8'hFF || last3[2] !== 8'h01) begin
      errors++;
      $display("FAIL multi_data got %h %h %h want 3c ff 01", last3[0], last3[1], last3[2]);
    end
  endtask

  task automatic test_back_to_back();
    int v0, e0;
    v0 = vcnt1; e0 = ecnt1;
    frame_begin();
    send_bits(8'h12, 8'h00, 8'h00, 8);
    send_bits(8'h34, 8'h00, 8'h00, 8);
    frame_end();
    checks++;
    if (vcnt1 - v0 != 2 || prev_val1 !== 8'h12 || last_val1 !== 8'h34) begin
      errors++;
      $display("FAIL b2b_words got n=%0d %h %h want n=2 12 34", vcnt1 - v0, prev_val1, last_val1);
    end
    checks++;
    if (last_t1 - prev_t1 != 8 * 2 * HALF) begin
      errors++;
      $display("FAIL b2b_spacing got %0d want %0d", last_t1 - prev_t1, 8 * 2 * HALF);
    end
    checks++;
    if (ecnt1 != e0) begin
      errors++;
      $display("FAIL b2b_err got %0d want 0", ecnt1 - e0);
    end
  endtask

  task automatic test_frame_err();
    int v0, e0;
    v0 = vcnt1; e0 = ecnt1;
    frame_begin();
    send_bits(8'hF0, 8'h00, 8'h00, 5);
    frame_end();
    checks++;
    if (ecnt1 - e0 != 1 || vcnt1 != v0) begin
      errors++;
      $display("FAIL ferr_pulse got err=%0d valid=%0d want err=1 valid=0", ecnt1 - e0, vcnt1 - v0);
    end
    checks++;
    if (d1[0] !== 8'h34) begin
      errors++;
      $display("FAIL ferr_hold got %h want 34", d1[0]);
    end
    frame_begin();
    send_bits(8'hC3, 8'h00, 8'h00, 8);
    frame_end();
    checks++;
    if (vcnt1 - v0 != 1 || last_val1 !== 8'hC3 || ecnt1 - e0 != 1) begin
      errors++;
      $display("FAIL ferr_recover got n=%0d val=%h err=%0d want n=1 val=c3 err=1",
               vcnt1 - v0, last_val1, ecnt1 - e0);
    end
  endtask

  task automatic test_reset_mid();
    int v0, e0;
    frame_begin();
    send_bits(8'hFF, 8'h00, 8'h00, 4);
    v0 = vcnt1; e0 = ecnt1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({d1, v1, e1, busy1} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs got d=%h v=%b e=%b b=%b want all 0", d1, v1, e1, busy1);
    end
    cs = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (vcnt1 != v0 || ecnt1 != e0) begin
      errors++;
      $display("FAIL rstmid_nostrobe got v=%0d e=%0d want 0 0", vcnt1 - v0, ecnt1 - e0);
    end
    frame_begin();
    send_bits(8'h5A, 8'h00, 8'h00, 8);
    frame_end();
    checks++;
    if (vcnt1 - v0 != 1 || last_val1 !== 8'h5A || ecnt1 != e0) begin
      errors++;
      $display("FAIL rstmid_word got n=%0d val=%h err=%0d want n=1 val=5a err=0",
               vcnt1 - v0, last_val1, ecnt1 - e0);
    end
  endtask

  task automatic test_idle_dclk();
    int v0, e0, b0;
    v0 = vcnt1 + vcnt3; e0 = ecnt1 + ecnt3; b0 = busy_hi;
    for (int i = 0; i < 20; i++) begin
      chip_data = 3'(i);
      repeat (5) @(negedge clk);
      dclk = ~dclk;
    end
    dclk = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (vcnt1 + vcnt3 != v0 || ecnt1 + ecnt3 != e0 || busy_hi != b0) begin
      errors++;
      $display("FAIL idle_dclk got v=%0d e=%0d busy=%0d want 0 0 0",
               vcnt1 + vcnt3 - v0, ecnt1 + ecnt3 - e0, busy_hi - b0);
    end
    checks++;
    if (d1[0] !== 8'h5A) begin
      errors++;
      $display("FAIL idle_hold got %h want 5a", d1[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_line();
    test_back_to_back();
    test_frame_err();
    test_reset_mid();
    test_idle_dclk();
    checks++;
    if (both_cnt != 0) begin
      errors++;
      $display("FAIL valid_err_overlap got %0d want 0", both_cnt);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_recv_con.md
# spi_recv_con

Main-FPGA-side SPI receiver for the peripheral-to-main depth-data link. It samples the peripheral's chip-select, data clock and 1..LINES data lines, all asynchronous to the system clock. It shifts in DATA_WIDTH bits per line, MSB first, on each data-clock rising edge. It then presents each completed word on all lines in parallel with a one-cycle valid strobe. It sits between the board-level SPI pins and the main FPGA's pixel/frame-buffer write logic.

## Interface
Parameters:
- DATA_WIDTH, 8, bits per word per line.
- LINES, 1, number of parallel data lines.
- SYNC_STAGES, 2, synchronizer depth (≥2) applied identically to chip_sel_in, chip_clk_in and every data line.

Ports:
- clk_in  input  1  system clock (100 MHz). Single clock domain.
- rst_n_in  input  1  reset, asynchronous assert, active-low.
- chip_data_in  input  [LINES-1:0]  CIPO lines from the peripheral. Asynchronous.
- chip_clk_in  input  1  DCLK from the peripheral. Idles low. Asynchronous.
- chip_sel_in  input  1  CS from the peripheral. Active-low. Asynchronous.
- data_out  output  [DATA_WIDTH-1:0] x [LINES-1:0]  last completed word per line.
- data_valid_out  output  1  one-cycle strobe, data_out newly updated.
- frame_err_out  output  1  one-cycle strobe, CS deasserted with a partial word pending.
- busy_out  output  1  high while synchronized CS is low.

## Operation
- Reset (rst_n_in low, asynchronous):
  - All synchronizer flops clear to 0, except the CS chain, which sets to 1.
  - The delayed-DCLK flop clears to 0.
  - Bit counter, shift registers, data_out, data_valid_out, frame_err_out and busy_out all clear to 0.
  - State goes to IDLE.
- Synchronization: every pin passes through SYNC_STAGES flops. "Sync" below means the last stage.
- Edge detect: a rise is sync DCLK = 1 while its one-cycle-delayed copy = 0. Falling edges are ignored; the transmitter changes data on falling edges.
- States:
  - IDLE: sync CS high. Rises are ignored. Go to RECV when sync CS = 0.
  - RECV: busy_out = 1.
    - On each rise, every line shifts in its sync data bit at the LSB: shift = {shift[DATA_WIDTH-2:0], bit}. The bit counter increments.
    - When the DATA_WIDTH-th bit shifts in (counter = DATA_WIDTH-1 before the rise):
      - data_out[line] takes the full word, with the newest bit as LSB.
      - data_valid_out pulses.
      - The counter wraps to 0 and the state stays RECV.
    - Back-to-back words inside one CS-low window (transmitter re-triggered before CS rises) are therefore received as successive words.
    - On sync CS = 1:
      - If the counter ≠ 0, pulse frame_err_out and discard the partial bits.
      - Clear the counter and go to IDLE.
- Simultaneous events:
  - If sync CS = 1 and a rise occur in the same cycle, CS wins: the rise is ignored and the CS rule above applies.
  - data_valid_out and frame_err_out are never high in the same cycle.
- data_out holds its value between words. There is no backpressure, so the consumer must take the word on the strobe.
- DCLK activity while CS is high has no effect on any output.

## Timing
- Let edge k be the first clk_in edge at which chip_clk_in reads high for the final bit.
  - data_out and data_valid_out update at edge k+SYNC_STAGES.
  - data_valid_out is high for exactly one cycle.
- Data lines share the DCLK synchronizer depth. The bit sampled is the pin value at the same clk_in edge as the DCLK rise.
- Requirement on the source: DCLK high and low phases each last ≥ SYNC_STAGES+1 clk_in cycles. Data must be stable from the preceding falling edge through that window.
- CS rise reaches busy_out low and any frame_err_out pulse SYNC_STAGES+1 edges after first being sampled high.
- CS fall reaches busy_out high SYNC_STAGES+1 edges after first being sampled low.
- frame_err_out is high for exactly one cycle.
- Reset mid-word: partial bits are lost. No strobe fires on either reset assertion or release.

## Test plan
- LINES=1, DCLK half-period 50 cycles, one word 8'hA5 -> exactly one data_valid_out pulse, data_out = 8'hA5, frame_err_out never high, busy_out falls after CS rises.
- LINES=3, words 8'h3C/8'hFF/8'h01 in one frame -> a single strobe with all three lines correct on that cycle.
- Two words 8'h12 then 8'h34 with CS held low (re-trigger) -> two strobes 8 DCLK rises apart, values 8'h12 then 8'h34, no frame_err_out.
- CS rises after 5 DCLK rises -> one frame_err_out pulse, no data_valid_out, data_out keeps its prior value. Next full word 8'hC3 is received correctly.
- Reset pulsed low after 4 bits, then a full frame 8'h5A -> all outputs 0 during reset, then a single strobe with 8'h5A.
- 20 DCLK toggles with CS high -> no strobes, busy_out stays 0.
